// File: rtl/param_matrix_multiplier.sv
// Streaming NxN matrix multiplier: loads A then B row-major, computes C with
// N parallel multipliers one element per cycle, then drains C row-major.
module param_matrix_multiplier #(
  parameter int N  = 3,
  parameter int DW = 4
) (
  input  logic                          clk_i,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          signed_mode,
  input  logic [DW-1:0]                 data_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [2*DW+$clog2(N)-1:0]     data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int OW = 2*DW + $clog2(N);
  localparam int NN = N*N;
  localparam int IW = $clog2(NN);
  localparam int RW = $clog2(N);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    COMPUTE,
    DRAIN
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [RW-1:0]   r_row;
  logic [RW-1:0]   r_col;
  logic            r_sgn;
  logic            r_ov;
  logic [DW-1:0]   r_a [NN];
  logic [DW-1:0]   r_b [NN];
  logic [OW-1:0]   r_c [NN];

  logic [IW-1:0]   w_ai [N];
  logic [IW-1:0]   w_bi [N];
  logic [OW-1:0]   w_ax [N];
  logic [OW-1:0]   w_bx [N];
  logic [OW-1:0]   w_prod [N];
  logic [OW-1:0]   w_sum;
  logic            w_last;
  logic            w_acc;
  logic            w_ohs;

  // One multiplier per k: A[row][k] * B[k][col], extended to OW first
  for (genvar k = 0; k < N; k++) begin : g_mul
    assign w_ai[k] = IW'(int'(r_row)*N + k);
    assign w_bi[k] = IW'(k*N + int'(r_col));
    assign w_ax[k] = r_sgn ? {{(OW-DW){r_a[w_ai[k]][DW-1]}}, r_a[w_ai[k]]}
                           : {{(OW-DW){1'b0}}, r_a[w_ai[k]]};
    assign w_bx[k] = r_sgn ? {{(OW-DW){r_b[w_bi[k]][DW-1]}}, r_b[w_bi[k]]}
                           : {{(OW-DW){1'b0}}, r_b[w_bi[k]]};
    assign w_prod[k] = w_ax[k] * w_bx[k];
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = w_sum + w_prod[k];
    end
  end

  assign w_last    = (r_idx == IW'(NN-1));
  assign in_ready  = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign w_acc     = in_valid && in_ready;
  assign w_ohs     = r_ov && out_ready;
  assign out_valid = r_ov;
  assign data_out  = r_ov ? r_c[r_idx] : '0;
  assign busy      = (r_state != LOAD_A);
  assign done      = w_ohs && w_last && !clear;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_state <= LOAD_A;
      r_idx   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_sgn   <= 1'b0;
      r_ov    <= 1'b0;
      for (int i = 0; i < NN; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
        r_c[i] <= '0;
      end
    end else if (clear) begin
      r_state <= LOAD_A;
      r_idx   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_ov    <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (w_acc) begin
            r_a[r_idx] <= data_in;
            if (r_idx == '0) r_sgn <= signed_mode;
            if (w_last) begin
              r_idx   <= '0;
              r_state <= LOAD_B;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (w_acc) begin
            r_b[r_idx] <= data_in;
            if (w_last) begin
              r_idx   <= '0;
              r_row   <= '0;
              r_col   <= '0;
              r_state <= COMPUTE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        COMPUTE: begin
          r_c[r_idx] <= w_sum;
          if (r_col == RW'(N-1)) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
          if (w_last) begin
            r_idx   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_ov    <= 1'b1;
            r_state <= DRAIN;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DRAIN: begin
          if (w_ohs) begin
            if (w_last) begin
              r_idx   <= '0;
              r_ov    <= 1'b0;
              r_state <= LOAD_A;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= LOAD_A;
      endcase
    end
  end

endmodule
